multiword_add_sequencer: RTL

- Upstream issue stage for the 32-bit bypass adder.
- Accepts a wide (WORDS×W-bit) add/subtract request over a valid/ready handshake and feeds the external combinational adder one W-bit word pair per cycle, LSW first.
- Chains the adder's carry-out into the next word's carry-in.
- Assembles the wide sum, final carry and signed overflow, and presents them on a valid/ready result port.

---
 rtl/multiword_add_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//   Issue stage for a single-word combinational adder. It takes one wide
//   (WORDS*W-bit) add request and feeds the external adder one word pair per
//   cycle, least significant word first. The adder's carry-out of each word
//   becomes the carry-in of the next word. When the last word is done, the
//   block presents the wide sum, the final carry and the signed overflow.
//
//   Optional feature: define ADDSEQ_SUB_EN to honour in_sub (A-B). B is then
//   inverted and the initial carry is forced to 1. When the macro is not
//   defined, in_sub is ignored and no inversion logic is built.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid/in_ready     request handshake
//   in_a, in_b            N-bit operands, N = W*WORDS
//   in_cin                initial carry-in (ignored when subtracting)
//   in_sub                1 = A-B (only honoured with ADDSEQ_SUB_EN)
//   add_a/add_b/add_cin   word operands sent to the external adder
//   add_s/add_cout        combinational result returned by the adder
//   out_valid/out_ready   result handshake
//   out_sum/out_cout/out_ovf  wide sum, final carry, signed overflow
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready=1; waits for a request
// RUN   | one word per cycle through the adder, idx = current word
// DONE  | result held on out_* until out_ready

module multiword_add_sequencer #(
  parameter int W     = 32,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W*WORDS-1:0] in_a,
  input  logic [W*WORDS-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  output logic             add_cin,
  input  logic [W-1:0]     add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W*WORDS-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int N     = W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [N-1:0]     a_reg, b_reg, sum_reg;
  logic             cout_reg, ovf_reg;
  logic [N-1:0]     b_eff;
  logic             cin_eff;

`ifdef ADDSEQ_SUB_EN
  // Two's-complement subtract: A + ~B + 1.
  assign b_eff   = in_sub ? ~in_b : in_b;
  assign cin_eff = in_sub | in_cin;
`else
  logic unused_in_sub;
  assign unused_in_sub = in_sub;
  assign b_eff   = in_b;
  assign cin_eff = in_cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= b_eff;
            carry <= cin_eff;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg[idx*W +: W] <= add_s;
          carry               <= add_cout;
          if (idx == LAST_IDX) begin
            cout_reg <= add_cout;
            // Overflow: operands share a sign but the top word's sum bit differs.
            ovf_reg  <= (a_reg[N-1] == b_reg[N-1]) & (add_s[W-1] != a_reg[N-1]);
            idx      <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        add_a   = a_reg[idx*W +: W];
        add_b   = b_reg[idx*W +: W];
        add_cin = carry;
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == DONE);
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;
  assign out_ovf   = ovf_reg;

endmodule
